// File: rtl/counter_pkg.sv
// Shared definitions for the simple counter set: default width and the
// down-counter control state encoding.
package counter_pkg;

    // Default counter and load-value width in bits.
    localparam int unsigned DEFAULT_WIDTH = 12;

    // Down-counter control state.
    //   IDLE    : no countdown loaded
    //   RUN     : counting down on enabled cycles
    //   EXPIRED : one-shot countdown reached 0; left only by load or reset
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUN     = 2'b01,
        ST_EXPIRED = 2'b10
    } cnt_state_t;

endpackage : counter_pkg

// File: rtl/counterdown12_1clk_async_resetp.sv
// Loadable down counter / one-shot timer with optional auto-reload.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   load         load strobe: captures load_value into count and reload register
//   load_value   start value for the countdown
//   enable       count enable; decrement only when high
//   auto_reload  1 = reload at terminal count (periodic), 0 = one-shot
//   count        current counter value (registered)
//   tc           terminal-count pulse, one cycle high (registered)
//   busy         high while counting (registered)
//   expired      high while a one-shot has finished (registered)
module counterdown12_1clk_async_resetp
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             expired
);

    cnt_state_t       state_q;
    cnt_state_t       state_d;
    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] reload_d;
    logic [WIDTH-1:0] count_d;
    logic             tc_d;
    logic             at_terminal;
    logic             can_decrement;

    // Terminal event is the enabled cycle at count==1, so 0 is only ever
    // shown in one-shot mode and the counter never borrows below 0.
    assign at_terminal   = (count == WIDTH'(1));
    assign can_decrement = (count > WIDTH'(1));

    // State register plus registered datapath and outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            reload_q <= '0;
            count    <= '0;
            tc       <= 1'b0;
            busy     <= 1'b0;
            expired  <= 1'b0;
        end else begin
            state_q  <= state_d;
            reload_q <= reload_d;
            count    <= count_d;
            tc       <= tc_d;
            busy     <= (state_d == ST_RUN);
            expired  <= (state_d == ST_EXPIRED);
        end
    end

    // Next-state and datapath: load > terminal/decrement > hold.
    always_comb begin
        state_d  = state_q;
        reload_d = reload_q;
        count_d  = count;
        tc_d     = 1'b0;

        if (load) begin
            // A load overrides any coincident terminal event, so no tc.
            count_d  = load_value;
            reload_d = load_value;
            state_d  = (load_value != '0) ? ST_RUN : ST_IDLE;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (enable) begin
                        if (at_terminal) begin
                            tc_d = 1'b1;
                            if (auto_reload) begin
                                count_d = reload_q;
                            end else begin
                                count_d = '0;
                                state_d = ST_EXPIRED;
                            end
                        end else if (can_decrement) begin
                            count_d = count - WIDTH'(1);
                        end
                    end
                end
                ST_IDLE, ST_EXPIRED: begin
                    // Count holds; enable is ignored.
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

endmodule : counterdown12_1clk_async_resetp
